// File: rtl/z80_io_pkg.sv
// rtl/z80_io_pkg.sv - shared Z80 I/O port constants, state and select types
//
// Purpose: common definitions for the Z80 I/O port blocks.
//   DATA_PORT_ADDR / STATUS_PORT_ADDR : default IN port addresses
//   CHANGED_BIT / OVERRUN_BIT         : flag positions in the status byte
//   state_t                           : IN-cycle responder states
//   sel_t                             : which port the current cycle reads
package z80_io_pkg;

  localparam logic [7:0] DATA_PORT_ADDR   = 8'hFE;
  localparam logic [7:0] STATUS_PORT_ADDR = 8'hFD;

  localparam int CHANGED_BIT = 7;
  localparam int OVERRUN_BIT = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRIVE
  } state_t;

  typedef enum logic {
    SEL_DATA,
    SEL_STATUS
  } sel_t;

  // Status byte layout: flags in the top bits, remaining bits read as zero.
  function automatic logic [7:0] status_byte(input logic changed, input logic overrun);
    logic [7:0] b;
    b              = 8'h00;
    b[CHANGED_BIT] = changed;
    b[OVERRUN_BIT] = overrun;
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized two-flop synchronizer
//
// Purpose: bring asynchronous inputs into the clk_i domain.
// Ports:
//   clk_i  : destination clock
//   rst_i  : asynchronous active-high reset, clears both stages
//   d_i    : asynchronous input bus
//   q_o    : synchronized bus, two clocks behind d_i
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/inport_responder.sv
// rtl/inport_responder.sv - Z80 IN-port responder for switch data and status
//
// Purpose: answers Z80 IN cycles on two ports, inserting WAIT states, and
// tracks change/overrun flags on eight synchronized switch inputs.
// Ports:
//   clock       : system clock, Z80 bus is synchronous to it
//   reset       : asynchronous active-high reset
//   address     : Z80 A0-A7, sampled only at the start of an IN cycle
//   n_iord      : active-low IORQ&RD strobe
//   switches    : asynchronous switch inputs
//   data_out    : byte for the CPU data-in mux (8'h00 when not driving)
//   data_out_en : high while data_out must be selected
//   n_wait      : active-low WAIT request
//   irq_pending : registered copy of the change flag
module inport_responder
  import z80_io_pkg::*;
#(
  parameter logic [7:0] DATA_PORT   = DATA_PORT_ADDR,
  parameter logic [7:0] STATUS_PORT = STATUS_PORT_ADDR,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       n_iord,
  input  logic [7:0] switches,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic       n_wait,
  output logic       irq_pending
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [7:0] sw_sync;
  logic [7:0] sw_prev_q;
  logic       changed_q, changed_d;
  logic       overrun_q, overrun_d;
  logic       n_iord_q;

  state_t     state_q;
  sel_t       sel_q;
  logic [7:0] data_q;
  logic [3:0] cnt_q;
  logic [7:0] data_out_q;
  logic       data_out_en_q;
  logic       n_wait_q;

  logic       start;
  logic       hit_data;
  logic       hit_status;
  logic [7:0] cap_byte;
  logic       chg;
  logic       drive_exit;
  logic       clr_changed;
  logic       clr_overrun;

  sync_2ff #(.WIDTH(8)) u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (switches),
    .q_o   (sw_sync)
  );

  always_comb begin
    start       = n_iord_q && !n_iord;
    hit_data    = (address == DATA_PORT);
    hit_status  = (address == STATUS_PORT);
    cap_byte    = hit_data ? sw_sync : status_byte(changed_q, overrun_q);
    chg         = (sw_sync != sw_prev_q);
    drive_exit  = (state_q == DRIVE) && n_iord;
    clr_changed = drive_exit && (sel_q == SEL_DATA);
    clr_overrun = drive_exit && (sel_q == SEL_STATUS);

    // A new change always wins over a read-clear in the same clock.
    changed_d = changed_q;
    overrun_d = overrun_q;
    if (clr_changed) changed_d = 1'b0;
    if (clr_overrun) overrun_d = 1'b0;
    if (chg) begin
      changed_d = 1'b1;
      if (changed_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_prev_q <= 8'h00;
      changed_q <= 1'b0;
      overrun_q <= 1'b0;
      n_iord_q  <= 1'b1;
    end else begin
      sw_prev_q <= sw_sync;
      changed_q <= changed_d;
      overrun_q <= overrun_d;
      n_iord_q  <= n_iord;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= SEL_DATA;
      data_q        <= 8'h00;
      cnt_q         <= 4'd0;
      data_out_q    <= 8'h00;
      data_out_en_q <= 1'b0;
      n_wait_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Only a falling strobe on a decoded address starts a cycle.
          if (start && (hit_data || hit_status)) begin
            data_q <= cap_byte;
            sel_q  <= hit_data ? SEL_DATA : SEL_STATUS;
            if (WAIT_CYCLES > 0) begin
              state_q  <= WAIT;
              n_wait_q <= 1'b0;
              cnt_q    <= CNT_INIT;
            end else begin
              state_q       <= DRIVE;
              data_out_q    <= cap_byte;
              data_out_en_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (n_iord) begin
            // Aborted cycle: release WAIT, flags untouched.
            state_q  <= IDLE;
            n_wait_q <= 1'b1;
          end else if (cnt_q == 4'd0) begin
            state_q       <= DRIVE;
            n_wait_q      <= 1'b1;
            data_out_q    <= data_q;
            data_out_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DRIVE: begin
          if (n_iord) begin
            state_q       <= IDLE;
            data_out_q    <= 8'h00;
            data_out_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_out_en = data_out_en_q;
  assign n_wait      = n_wait_q;
  assign irq_pending = changed_q;

endmodule

// File: tb/tb_inport_responder.sv
// tb/tb_inport_responder.sv - self-checking bench for inport_responder
module tb_inport_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = 8'h00;
  logic       n_iord = 1'b1;
  logic [7:0] switches = 8'h00;

  logic [7:0] data_out;
  logic       data_out_en, n_wait, irq_pending;
  logic [7:0] data_out_z;
  logic       data_out_en_z, n_wait_z, irq_pending_z;

  int total = 0;
  int passed = 0;

  // Reference model: flag state and the settled switch value seen by the DUT.
  bit         m_changed = 0;
  bit         m_overrun = 0;
  logic [7:0] m_sw = 8'h00;
  bit         z_wait_seen = 0;

  inport_responder dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .n_iord      (n_iord),
    .switches    (switches),
    .data_out    (data_out),
    .data_out_en (data_out_en),
    .n_wait      (n_wait),
    .irq_pending (irq_pending)
  );

  inport_responder #(.WAIT_CYCLES(0)) dut_z (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .n_iord      (n_iord),
    .switches    (switches),
    .data_out    (data_out_z),
    .data_out_en (data_out_en_z),
    .n_wait      (n_wait_z),
    .irq_pending (irq_pending_z)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (!reset && n_wait_z !== 1'b1) z_wait_seen = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_change(input logic [7:0] v);
    if (v != m_sw) begin
      if (m_changed) m_overrun = 1;
      m_changed = 1;
      m_sw = v;
    end
  endfunction

  function automatic logic [7:0] model_status();
    return (m_changed ? 8'h80 : 8'h00) | (m_overrun ? 8'h40 : 8'h00);
  endfunction

  task automatic set_sw(input logic [7:0] v);
    @(negedge clock);
    switches = v;
    repeat (4) @(negedge clock);
    model_change(v);
    chk("irq_after_switch", irq_pending, m_changed);
  endtask

  task automatic do_in(input logic [7:0] addr, input bit abort);
    bit         decoded;
    bit         got;
    int         waits;
    logic [7:0] exp;
    decoded = (addr == 8'hFE) || (addr == 8'hFD);
    exp     = (addr == 8'hFE) ? m_sw : model_status();
    got     = 0;
    waits   = 0;
    @(negedge clock);
    address = addr;
    n_iord  = 1'b0;
    if (abort) begin
      @(negedge clock);
      if (decoded) chk("abort_wait_low", n_wait, 1'b0);
      n_iord = 1'b1;
      @(negedge clock);
      chk("abort_wait_released", n_wait, 1'b1);
      chk("abort_no_drive", data_out_en, 1'b0);
      repeat (2) @(negedge clock);
      chk("abort_flags_kept", irq_pending, m_changed);
      address = 8'h00;
      return;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (i == 0) begin
        address = 8'($urandom);
        if (addr == 8'hFE) begin
          chk("zero_wait_en", data_out_en_z, 1'b1);
          chk("zero_wait_data", data_out_z, exp);
        end
      end
      if (n_wait === 1'b0) waits++;
      if (data_out_en === 1'b1) begin
        got = 1;
        break;
      end
      if (!decoded && i == 8) break;
    end
    if (decoded) begin
      chk("drive_reached", got, 1'b1);
      chk("wait_clocks", waits, 2);
      chk("drive_data", data_out, exp);
      @(negedge clock);
      chk("drive_hold_en", data_out_en, 1'b1);
      chk("drive_hold_data", data_out, exp);
    end else begin
      chk("nodecode_no_drive", got, 1'b0);
      chk("nodecode_no_wait", waits, 0);
    end
    n_iord = 1'b1;
    @(negedge clock);
    chk("end_en_low", data_out_en, 1'b0);
    chk("end_data_zero", data_out, 8'h00);
    chk("end_wait_high", n_wait, 1'b1);
    if (addr == 8'hFE) m_changed = 0;
    if (addr == 8'hFD) m_overrun = 0;
    chk("end_irq", irq_pending, m_changed);
    address = 8'h00;
  endtask

  initial begin
    bit         got;
    logic [7:0] a;
    #12;
    chk("reset_data", data_out, 8'h00);
    chk("reset_en", data_out_en, 1'b0);
    chk("reset_wait", n_wait, 1'b1);
    chk("reset_irq", irq_pending, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    set_sw(8'hA5);
    do_in(8'hFE, 0);

    set_sw(8'h00);
    do_in(8'hFE, 0);
    set_sw(8'h01);
    set_sw(8'h03);
    do_in(8'hFD, 0);
    do_in(8'hFD, 0);
    do_in(8'hFE, 0);

    do_in(8'h10, 0);

    // Switch change reaching the flag logic in the same clock a data read ends.
    @(negedge clock);
    address = 8'hFE;
    n_iord  = 1'b0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (data_out_en === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("race_drive_reached", got, 1'b1);
    switches = 8'h3C;
    @(negedge clock);
    @(negedge clock);
    n_iord = 1'b1;
    @(negedge clock);
    m_changed = 0;
    model_change(8'h3C);
    chk("race_end_en", data_out_en, 1'b0);
    chk("race_changed_kept", irq_pending, 1'b1);
    repeat (2) @(negedge clock);
    do_in(8'hFD, 0);

    do_in(8'hFE, 1);
    do_in(8'hFE, 0);

    // Reset while driving.
    set_sw(8'h5A);
    @(negedge clock);
    address = 8'hFE;
    n_iord  = 1'b0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (data_out_en === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("rst_drive_reached", got, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_data", data_out, 8'h00);
    chk("rst_mid_en", data_out_en, 1'b0);
    chk("rst_mid_wait", n_wait, 1'b1);
    chk("rst_mid_irq", irq_pending, 1'b0);
    n_iord = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_changed = 0;
    m_overrun = 0;
    m_sw = 8'h00;
    repeat (4) @(negedge clock);
    model_change(switches);
    chk("post_reset_irq", irq_pending, m_changed);
    do_in(8'hFD, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: set_sw(8'($urandom));
        1: do_in(8'hFE, 0);
        2: do_in(8'hFD, 0);
        3: begin
          a = 8'($urandom);
          while (a == 8'hFE || a == 8'hFD) a = 8'($urandom);
          do_in(a, 0);
        end
        default: do_in(($urandom_range(0, 1) == 0) ? 8'hFE : 8'hFD, 1);
      endcase
    end

    chk("zero_wait_never_low", z_wait_seen, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
